// File: rtl/level_meter_hold_if.sv
// Purpose : carries one window's level result from the decibel-bin stage to the meter.
// Latency : none; this is only a bundle of wires.
// Backpressure: none; the consumer may drop levels itself via freeze.
// Ports   : level_in[3:0] bin index, level_valid one-cycle strobe, freeze hold request.
interface level_meter_hold_if;
  logic [3:0] level_in;
  logic       level_valid;
  logic       freeze;

  modport master (
    output level_in,
    output level_valid,
    output freeze
  );

  modport slave (
    input level_in,
    input level_valid,
    input freeze
  );
endinterface

// File: rtl/level_meter_hold.sv
// Purpose : running-average and peak-hold level meter with overload flag, LED bar and 7-seg drive.
// Latency : accept sampled at edge T, internal state at T+1, registered outputs and update_pulse at T+2.
// Backpressure: none; freeze=1 drops new strobes, in-flight accepts still complete.
// Ports   : clock, resetn (sync, active-low), lvl_if (level_in/level_valid/freeze),
//           avg_level, peak_level, overload, bar_leds, hex_avg, hex_peak, update_pulse.
module level_meter_hold #(
  parameter int AVG_DEPTH    = 4,
  parameter int HOLD_WINDOWS = 6,
  parameter int OVL_COUNT    = 3
) (
  input  logic                     clock,
  input  logic                     resetn,
  level_meter_hold_if.slave        lvl_if,
  output logic [3:0]               avg_level,
  output logic [3:0]               peak_level,
  output logic                     overload,
  output logic [9:0]               bar_leds,
  output logic [6:0]               hex_avg,
  output logic [6:0]               hex_peak,
  output logic                     update_pulse
);

  localparam int LOG2D = $clog2(AVG_DEPTH);
  localparam int SW    = 4 + LOG2D;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    DECAY = 2'd2
  } peak_state_t;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      default: s = 7'b0010000;
    endcase
    return s;
  endfunction

  // Stage 0: capture the accept and clamp the level to 9.
  logic       acc_q;
  logic [3:0] lvl_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc_q <= 1'b0;
      lvl_q <= 4'd0;
    end else begin
      acc_q <= lvl_if.level_valid & ~lvl_if.freeze;
      lvl_q <= (lvl_if.level_in > 4'd9) ? 4'd9 : lvl_if.level_in;
    end
  end

  // Stage 1: averager, peak FSM, overload counter.
  logic [3:0]       ring [AVG_DEPTH];
  logic [LOG2D-1:0] wpr_q;
  logic [SW-1:0]    sum_q;
  logic [1:0]       ovl_cnt_q;
  logic [1:0]       ovl_cnt_d;
  logic             upd_q;

  peak_state_t state_q, state_d;
  logic [3:0]  peak_q, peak_d;
  logic [3:0]  cnt_q, cnt_d;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < AVG_DEPTH; i++) ring[i] <= 4'd0;
      wpr_q     <= '0;
      sum_q     <= '0;
      ovl_cnt_q <= 2'd0;
      upd_q     <= 1'b0;
      state_q   <= IDLE;
      peak_q    <= 4'd0;
      cnt_q     <= 4'd0;
    end else begin
      upd_q <= acc_q;
      if (acc_q) begin
        // Slot being overwritten leaves the sum as the new level enters it.
        sum_q       <= sum_q - SW'(ring[wpr_q]) + SW'(lvl_q);
        ring[wpr_q] <= lvl_q;
        // AVG_DEPTH is a power of two, so the pointer wraps naturally.
        wpr_q       <= wpr_q + LOG2D'(1);
        ovl_cnt_q   <= ovl_cnt_d;
        state_q     <= state_d;
        peak_q      <= peak_d;
        cnt_q       <= cnt_d;
      end
    end
  end

  always_comb begin
    ovl_cnt_d = 2'd0;
    if (lvl_q == 4'd9) begin
      ovl_cnt_d = (ovl_cnt_q >= 2'(OVL_COUNT)) ? ovl_cnt_q : ovl_cnt_q + 2'd1;
    end
  end

  // Peak FSM next state; only consulted on an accept.
  always_comb begin
    state_d = state_q;
    peak_d  = peak_q;
    cnt_d   = cnt_q;
    if (lvl_q >= peak_q) begin
      peak_d  = lvl_q;
      cnt_d   = 4'(HOLD_WINDOWS);
      state_d = (lvl_q == 4'd0) ? IDLE : HOLD;
    end else begin
      // IDLE always has peak 0, so a smaller level only arrives in HOLD/DECAY.
      case (state_q)
        HOLD: begin
          if (cnt_q == 4'd1) state_d = DECAY;
          else               cnt_d   = cnt_q - 4'd1;
        end
        DECAY: begin
          peak_d = peak_q - 4'd1;
          if (peak_q == 4'd1) state_d = IDLE;
        end
        default: ;
      endcase
    end
  end

  // Stage 2: derive display values from the stage-1 state and register them.
  logic [3:0] avg_d;
  logic       ovl_d;
  logic [9:0] bar_d;

  always_comb begin
    avg_d = 4'((sum_q + SW'(AVG_DEPTH / 2)) >> LOG2D);
    ovl_d = (ovl_cnt_q >= 2'(OVL_COUNT));
    bar_d = '0;
    for (int i = 0; i < 9; i++) begin
      bar_d[i] = (4'(i) < avg_d) || ((peak_q != 4'd0) && (4'(i) == peak_q - 4'd1));
    end
    bar_d[9] = ovl_d;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      avg_level    <= 4'd0;
      peak_level   <= 4'd0;
      overload     <= 1'b0;
      bar_leds     <= 10'd0;
      hex_avg      <= 7'b1000000;
      hex_peak     <= 7'b1000000;
      update_pulse <= 1'b0;
    end else begin
      update_pulse <= upd_q;
      if (upd_q) begin
        avg_level  <= avg_d;
        peak_level <= peak_q;
        overload   <= ovl_d;
        bar_leds   <= bar_d;
        hex_avg    <= seg7(avg_d);
        hex_peak   <= seg7(peak_q);
      end
    end
  end

endmodule

// File: tb/tb_level_meter_hold.sv
module tb_level_meter_hold;
  logic       clock = 1'b0;
  logic       resetn;
  logic [3:0] avg_level;
  logic [3:0] peak_level;
  logic       overload;
  logic [9:0] bar_leds;
  logic [6:0] hex_avg;
  logic [6:0] hex_peak;
  logic       update_pulse;

  int n_vec = 0;
  int n_err = 0;

  level_meter_hold_if lvl_if ();

  level_meter_hold #(
    .AVG_DEPTH   (4),
    .HOLD_WINDOWS(2),
    .OVL_COUNT   (3)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .lvl_if      (lvl_if.slave),
    .avg_level   (avg_level),
    .peak_level  (peak_level),
    .overload    (overload),
    .bar_leds    (bar_leds),
    .hex_avg     (hex_avg),
    .hex_peak    (hex_peak),
    .update_pulse(update_pulse)
  );

  always #5 clock = ~clock;

  // Drive inputs at a negedge, cross one posedge, return at the next negedge.
  task automatic step(input logic v, input logic [3:0] l, input logic f);
    lvl_if.level_valid = v;
    lvl_if.level_in    = l;
    lvl_if.freeze      = f;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    resetn = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (avg_level !== 4'd0) begin $display("FAIL reset avg_level: got %0d want 0", avg_level); n_err++; end
    n_vec++; if (peak_level !== 4'd0) begin $display("FAIL reset peak_level: got %0d want 0", peak_level); n_err++; end
    n_vec++; if (overload !== 1'b0) begin $display("FAIL reset overload: got %b want 0", overload); n_err++; end
    n_vec++; if (bar_leds !== 10'd0) begin $display("FAIL reset bar_leds: got %b want 0000000000", bar_leds); n_err++; end
    n_vec++; if (hex_avg !== 7'b1000000) begin $display("FAIL reset hex_avg: got %b want 1000000", hex_avg); n_err++; end
    n_vec++; if (hex_peak !== 7'b1000000) begin $display("FAIL reset hex_peak: got %b want 1000000", hex_peak); n_err++; end
    n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL reset update_pulse: got %b want 0", update_pulse); n_err++; end
  endtask

  task automatic test_averaging();
    logic [3:0] exp_avg [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) step(1'b1, 4'd8, 1'b0);
      else       step(1'b0, 4'd0, 1'b0);
      if (c >= 2) begin
        n_vec++; if (avg_level !== exp_avg[c-2]) begin $display("FAIL avg_seq[%0d]: got %0d want %0d", c-2, avg_level, exp_avg[c-2]); n_err++; end
        n_vec++; if (update_pulse !== 1'b1) begin $display("FAIL avg_pulse[%0d]: got %b want 1", c-2, update_pulse); n_err++; end
      end else begin
        n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL avg_early_pulse[%0d]: got %b want 0", c, update_pulse); n_err++; end
      end
    end
    n_vec++; if (hex_avg !== 7'b0000000) begin $display("FAIL avg_hex: got %b want 0000000", hex_avg); n_err++; end
    n_vec++; if (bar_leds !== 10'b0011111111) begin $display("FAIL avg_bar: got %b want 0011111111", bar_leds); n_err++; end
    n_vec++; if (peak_level !== 4'd8) begin $display("FAIL avg_peak: got %0d want 8", peak_level); n_err++; end
    step(1'b0, 4'd0, 1'b0);
    n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL avg_pulse_end: got %b want 0", update_pulse); n_err++; end
  endtask

  task automatic test_peak_hold();
    logic [3:0] lv       [6] = '{4'd7, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [3:0] exp_peak [6] = '{4'd7, 4'd7, 4'd7, 4'd6, 4'd5, 4'd4};
    logic [3:0] exp_avg  [6] = '{4'd2, 4'd2, 4'd3, 4'd3, 4'd2, 4'd2};
    do_reset();
    for (int c = 0; c < 8; c++) begin
      if (c < 6) step(1'b1, lv[c], 1'b0);
      else       step(1'b0, 4'd0, 1'b0);
      if (c >= 2) begin
        n_vec++; if (peak_level !== exp_peak[c-2]) begin $display("FAIL peak_seq[%0d]: got %0d want %0d", c-2, peak_level, exp_peak[c-2]); n_err++; end
        n_vec++; if (avg_level !== exp_avg[c-2]) begin $display("FAIL peak_avg[%0d]: got %0d want %0d", c-2, avg_level, exp_avg[c-2]); n_err++; end
      end
      if (c == 2) begin
        n_vec++; if (bar_leds !== 10'b0001000011) begin $display("FAIL peak_bar_first: got %b want 0001000011", bar_leds); n_err++; end
      end
    end
    n_vec++; if (hex_peak !== 7'b0011001) begin $display("FAIL peak_hex: got %b want 0011001", hex_peak); n_err++; end
  endtask

  task automatic test_overload();
    logic [3:0] lv      [4] = '{4'd12, 4'd9, 4'd9, 4'd5};
    logic       exp_ovl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0] exp_avg [4] = '{4'd2, 4'd5, 4'd7, 4'd8};
    do_reset();
    for (int c = 0; c < 6; c++) begin
      if (c < 4) step(1'b1, lv[c], 1'b0);
      else       step(1'b0, 4'd0, 1'b0);
      if (c >= 2) begin
        n_vec++; if (overload !== exp_ovl[c-2]) begin $display("FAIL ovl_flag[%0d]: got %b want %b", c-2, overload, exp_ovl[c-2]); n_err++; end
        n_vec++; if (bar_leds[9] !== exp_ovl[c-2]) begin $display("FAIL ovl_led9[%0d]: got %b want %b", c-2, bar_leds[9], exp_ovl[c-2]); n_err++; end
        n_vec++; if (peak_level !== 4'd9) begin $display("FAIL ovl_peak[%0d]: got %0d want 9", c-2, peak_level); n_err++; end
        n_vec++; if (avg_level !== exp_avg[c-2]) begin $display("FAIL ovl_avg[%0d]: got %0d want %0d", c-2, avg_level, exp_avg[c-2]); n_err++; end
      end
    end
    n_vec++; if (hex_peak !== 7'b0010000) begin $display("FAIL ovl_hex_peak: got %b want 0010000", hex_peak); n_err++; end
  endtask

  task automatic test_freeze();
    do_reset();
    step(1'b1, 4'd6, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    n_vec++; if (bar_leds !== 10'b0000100011) begin $display("FAIL frz_setup_bar: got %b want 0000100011", bar_leds); n_err++; end
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 4'd9, 1'b1);
      n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL frz_pulse[%0d]: got %b want 0", c, update_pulse); n_err++; end
      n_vec++; if (avg_level !== 4'd2) begin $display("FAIL frz_avg[%0d]: got %0d want 2", c, avg_level); n_err++; end
      n_vec++; if (peak_level !== 4'd6) begin $display("FAIL frz_peak[%0d]: got %0d want 6", c, peak_level); n_err++; end
      n_vec++; if (overload !== 1'b0) begin $display("FAIL frz_ovl[%0d]: got %b want 0", c, overload); n_err++; end
    end
    // Accept 3, then re-freeze at once: the in-flight accept must still land.
    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd9, 1'b1);
    step(1'b1, 4'd9, 1'b1);
    n_vec++; if (update_pulse !== 1'b1) begin $display("FAIL frz_resume_pulse: got %b want 1", update_pulse); n_err++; end
    n_vec++; if (avg_level !== 4'd2) begin $display("FAIL frz_resume_avg: got %0d want 2", avg_level); n_err++; end
    n_vec++; if (peak_level !== 4'd6) begin $display("FAIL frz_resume_peak: got %0d want 6", peak_level); n_err++; end
    step(1'b1, 4'd9, 1'b1);
    n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL frz_after_pulse: got %b want 0", update_pulse); n_err++; end
    step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 4'd9, 1'b0);
    resetn = 1'b0;
    step(1'b0, 4'd0, 1'b0);
    resetn = 1'b1;
    step(1'b0, 4'd0, 1'b0);
    n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL rmid_pulse: got %b want 0", update_pulse); n_err++; end
    n_vec++; if (peak_level !== 4'd0) begin $display("FAIL rmid_peak: got %0d want 0", peak_level); n_err++; end
    n_vec++; if (avg_level !== 4'd0) begin $display("FAIL rmid_avg: got %0d want 0", avg_level); n_err++; end
    n_vec++; if (bar_leds !== 10'd0) begin $display("FAIL rmid_bar: got %b want 0000000000", bar_leds); n_err++; end
    n_vec++; if (hex_peak !== 7'b1000000) begin $display("FAIL rmid_hex_peak: got %b want 1000000", hex_peak); n_err++; end
    step(1'b0, 4'd0, 1'b0);
    n_vec++; if (update_pulse !== 1'b0) begin $display("FAIL rmid_pulse_late: got %b want 0", update_pulse); n_err++; end
    step(1'b1, 4'd4, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    step(1'b0, 4'd0, 1'b0);
    n_vec++; if (update_pulse !== 1'b1) begin $display("FAIL rmid_next_pulse: got %b want 1", update_pulse); n_err++; end
    n_vec++; if (avg_level !== 4'd1) begin $display("FAIL rmid_next_avg: got %0d want 1", avg_level); n_err++; end
    n_vec++; if (peak_level !== 4'd4) begin $display("FAIL rmid_next_peak: got %0d want 4", peak_level); n_err++; end
    n_vec++; if (hex_avg !== 7'b1111001) begin $display("FAIL rmid_next_hex_avg: got %b want 1111001", hex_avg); n_err++; end
    n_vec++; if (hex_peak !== 7'b0011001) begin $display("FAIL rmid_next_hex_peak: got %b want 0011001", hex_peak); n_err++; end
  endtask

  initial begin
    resetn             = 1'b0;
    lvl_if.level_in    = 4'd0;
    lvl_if.level_valid = 1'b0;
    lvl_if.freeze      = 1'b0;
    @(negedge clock);
    test_reset();
    test_averaging();
    test_peak_hold();
    test_overload();
    test_freeze();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/level_meter_hold.md
Name: level_meter_hold

Overview:
- Downstream consumer of the decibel-bin stage: takes each window's winning bin index (0-9) plus its one-cycle strobe.
- Produces a smoothed level as a running average over the last AVG_DEPTH windows.
- Produces a peak-hold level with a hold-then-decay state machine, plus an overload flag.
- Drives the DE1-SoC LEDR bar graph and two active-low 7-segment digits.

Parameters:
- AVG_DEPTH, 4, number of windows averaged; power of 2, range 2-16.
- HOLD_WINDOWS, 6, accepted windows the peak is held before decaying; range 1-15.
- OVL_COUNT, 3, consecutive level-9 windows needed to assert overload; range 1-3.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- resetn  in  1  synchronous reset, active-low
- level_in  in  4  bin index from the histogram stage
- level_valid  in  1  one-cycle strobe qualifying level_in
- freeze  in  1  1 = ignore new levels and hold all outputs
- avg_level  out  4  rounded running average, 0-9
- peak_level  out  4  peak-hold value, 0-9
- overload  out  1  sustained level-9 indicator
- bar_leds  out  10  LEDR bar graph
- hex_avg  out  7  active-low segments for avg_level
- hex_peak  out  7  active-low segments for peak_level
- update_pulse  out  1  one-cycle strobe when outputs change

Behaviour:
- Accept condition: level_valid=1 and freeze=0 at a rising clock edge. Back-to-back accepts on every cycle must be supported.
- Clamping: a level_in value above 9 is treated as 9.
- Pipeline: an accept at cycle T updates internal state at T+1. All outputs are registered, change at T+2, and update_pulse=1 at T+2 only.
- Averager: ring buffer of AVG_DEPTH 4-bit entries, write pointer wpr, and sum register of width 4+log2(AVG_DEPTH).
  - On accept: sum <= sum - buf[wpr] + L; buf[wpr] <= L; wpr wraps from AVG_DEPTH-1 to 0.
  - avg_level = (sum + AVG_DEPTH/2) >> log2(AVG_DEPTH). The buffer is zero after reset, so the average ramps up.
- Peak FSM: states IDLE, HOLD, DECAY, with hold counter cnt. L is the accepted level and P is the current peak.
  - If L >= P: P <= L, cnt <= HOLD_WINDOWS, state <= HOLD; if L=0, state <= IDLE.
  - Else, in HOLD: if cnt=1, state <= DECAY; otherwise cnt <= cnt-1. P is unchanged.
  - Else, in DECAY: P <= P-1. If P-1=0, state <= IDLE.
  - The FSM advances only on accepts.
- Overload: saturating counter of consecutive accepted levels equal to 9.
  - overload=1 once the counter reaches OVL_COUNT.
  - Cleared, together with the counter, on the first accepted level below 9.
- bar_leds:
  - bar_leds[i] = (i < avg_level) OR (peak_level != 0 AND i = peak_level-1), for i = 0..8.
  - bar_leds[9] = overload.
- 7-segment encoding: bit0=a through bit6=g, 0 = lit. Digit codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- freeze=1: level_valid is ignored, nothing advances, outputs hold, and no update_pulse is generated. An accept already in flight still completes.
- Reset (resetn=0 at an edge):
  - avg_level=0, peak_level=0, overload=0, bar_leds=0, update_pulse=0.
  - hex_avg and hex_peak = 1000000.
  - Buffer, sum, wpr, cnt and overload counter cleared; FSM in IDLE.
  - Reset dominates any simultaneous accept. An in-flight accept is discarded and produces no update_pulse after reset.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> all outputs are the reset values; hex_avg=hex_peak=1000000.
- Averaging (AVG_DEPTH=4): accept 8,8,8,8 back-to-back -> avg_level sequence 2,4,6,8. Each value arrives 2 cycles after its accept with an update_pulse each cycle. Final hex_avg=0000000 and bar_leds=0011111111.
- Peak hold/decay (HOLD_WINDOWS=2): accept 7,2,2,2,2,2 -> peak_level sequence 7,7,7,6,5,4, with bar_leds[6] lit after the first update.
- Clamp and overload (OVL_COUNT=3): accept 12,9,9 -> overload rises on the third update, peak_level=9, bar_leds[9]=1. Then accept 5 -> overload=0 on that update.
- Freeze: with freeze=1, pulse level_valid with 9 for 10 cycles -> no update_pulse and all outputs unchanged. After freeze=0, an accept of 3 updates normally.
- Reset mid-operation: accept 9 at T and assert resetn=0 at T+1 -> at T+2 all outputs are the reset values with no update_pulse. A subsequent accept of 4 -> avg_level=1, peak_level=4.
